// File: rtl/shared_output_arbiter.sv
// Round-robin arbiter for one shared output; ARB_TIMEOUT_EN adds a MAX_HOLD tenure limit with timeout pulse.
// Latency: grant one cycle after req is sampled; at least one dead (GAP) cycle between tenures.
// Backpressure: none; a requester holds req until served, an owner keeps grant until it drops req.
module shared_output_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         owner,
  output logic               busy,
  output logic               timeout
);

  localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_param_check
    $error("shared_output_arbiter: NUM_REQ must be 2..8 and MAX_HOLD 2..255");
  end

  logic [1:0]         state_q,   state_d;
  logic [NUM_REQ-1:0] grant_q,   grant_d;
  logic [2:0]         owner_q,   owner_d;
  logic               busy_q,    busy_d;
  logic               timeout_q, timeout_d;
  logic [PTR_W-1:0]   rr_ptr_q,  rr_ptr_d;

  logic               hi_vld, lo_vld;
  logic [2:0]         hi_idx, lo_idx, win_idx;
  logic [PTR_W-1:0]   ptr_nxt;
  logic               owner_req;

  // Descending scan: the last hit seen is the lowest index, both overall and at/above rr_ptr.
  always_comb begin
    hi_vld = 1'b0;
    hi_idx = 3'd0;
    lo_vld = 1'b0;
    lo_idx = 3'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_vld = 1'b1;
        lo_idx = 3'(i);
        if (i >= int'(rr_ptr_q)) begin
          hi_vld = 1'b1;
          hi_idx = 3'(i);
        end
      end
    end
  end

  assign win_idx   = hi_vld ? hi_idx : lo_idx;
  assign ptr_nxt   = (int'(win_idx) == NUM_REQ - 1) ? '0 : PTR_W'(win_idx + 3'd1);
  assign owner_req = |(req & grant_q);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
  logic [7:0] hold_q, hold_d;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    rr_ptr_d  = rr_ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    case (state_q)
      ST_GRANT: begin
        if (!owner_req) begin
          state_d = ST_GAP;
          grant_d = '0;
          busy_d  = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q >= HOLD_LIM) begin
          state_d   = ST_GAP;
          grant_d   = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: begin
        // IDLE and the single GAP cycle both evaluate requests afresh.
        if (lo_vld) begin
          state_d  = ST_GRANT;
          grant_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          owner_d  = win_idx;
          busy_d   = 1'b1;
          rr_ptr_d = ptr_nxt;
`ifdef ARB_TIMEOUT_EN
          hold_d   = 8'd1;
`endif
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= 3'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= 8'd0;
    end else begin
      hold_q <= hold_d;
    end
  end
`endif

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_shared_output_arbiter.sv
// Bench for shared_output_arbiter: directed scenarios then random request patterns against a tenure-level model.
module tb_shared_output_arbiter;

  localparam int N  = 4;
  localparam int MH = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req     = '0;
  logic [N-1:0] grant;
  logic [2:0]   owner;
  logic         busy;
  logic         timeout;

  int compared   = 0;
  int mismatched = 0;

  shared_output_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .grant   (grant),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clock = ~clock;

  // Reference: who holds the resource, for how long, and where the next search starts.
  bit m_busy;
  bit m_to;
  int m_owner;
  int m_len;
  int m_ptr;

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_to    = 1'b0;
    m_owner = 0;
    m_len   = 0;
    m_ptr   = 0;
  endfunction

  function automatic void model_clock(logic [N-1:0] r);
    bit found;
    int idx;
    if (m_busy) begin
      if (((r >> m_owner) & 1) == 0) begin
        m_busy = 1'b0;
        m_to   = 1'b0;
      end else if (TO_EN && m_len == MH) begin
        m_busy = 1'b0;
        m_to   = 1'b1;
      end else begin
        m_len++;
      end
    end else begin
      m_to  = 1'b0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && ((r >> idx) & 1) != 0) begin
          found   = 1'b1;
          m_busy  = 1'b1;
          m_owner = idx;
          m_len   = 1;
          m_ptr   = (idx + 1) % N;
        end
      end
    end
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [31:0] exp_grant;
    exp_grant = m_busy ? (32'd1 << m_owner) : 32'd0;
    check({tag, "_grant"}, 32'(grant), exp_grant);
    check({tag, "_busy"}, 32'(busy), 32'(m_busy));
    check({tag, "_timeout"}, 32'(timeout), 32'(m_to));
    check({tag, "_onehot0"}, 32'($onehot0(grant)), 32'd1);
    if (m_busy) check({tag, "_owner"}, 32'(owner), 32'(m_owner));
  endtask

  task automatic step(logic [N-1:0] r, string tag);
    req = r;
    @(posedge clock);
    model_clock(r);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(string tag);
    req     = '0;
    reset_n = 1'b0;
    model_reset();
    #1;
    check({tag, "_rst_grant"}, 32'(grant), 32'd0);
    check({tag, "_rst_owner"}, 32'(owner), 32'd0);
    check({tag, "_rst_busy"}, 32'(busy), 32'd0);
    check({tag, "_rst_timeout"}, 32'(timeout), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int seq [5] = '{1, 2, 4, 8, 1};
    int run;
    int to_seen;
    bit done;
    logic [N-1:0] r;
    int len;

    // Reset, then a single requester: grant one cycle after sampling.
    do_reset("r026");
    step(4'b0001, "r026");
    check("r026_grant_c", 32'(grant), 32'h1);
    check("r026_owner_c", 32'(owner), 32'd0);
    check("r026_busy_c", 32'(busy), 32'd1);

    // All requesting, each owner releases after two cycles: strict rotation with a gap.
    do_reset("r027");
    for (int k = 0; k < 5; k++) begin
      step(4'hF, "r027");
      check("r027_seq", 32'(grant), 32'(seq[k]));
      step(4'hF, "r027");
      step(4'hF & ~4'(seq[k]), "r027");
      check("r027_gap", 32'(grant), 32'd0);
    end

    // One requester holding forever: tenure limit (or unlimited hold).
    do_reset("r028");
    run = 0;
    to_seen = 0;
    done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step(4'b0010, "r028");
      if (!done) begin
        if (grant == 4'b0010) run++;
        else done = 1'b1;
      end
      if (timeout) to_seen++;
    end
    check("r028_run", 32'(run), TO_EN ? 32'd8 : 32'd100);
    check("r028_timeouts", 32'(to_seen), TO_EN ? 32'd11 : 32'd0);

    // Reset mid-tenure drops grant at once and restarts the pointer at 0.
    do_reset("r030");
    step(4'b0100, "r030");
    check("r030_owner2", 32'(owner), 32'd2);
    step(4'b0100, "r030");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("r030_async_grant", 32'(grant), 32'd0);
    check("r030_async_busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    check("r030_held_grant", 32'(grant), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step(4'b0110, "r030");
    check("r030_next_grant", 32'(grant), 32'h2);

    // Release coinciding with the hold limit is a plain release.
    do_reset("r031");
    for (int c = 0; c < 8; c++) step(4'b0010, "r031");
    step(4'b0000, "r031");
    check("r031_grant", 32'(grant), 32'd0);
    check("r031_timeout", 32'(timeout), 32'd0);
    step(4'b0000, "r031");

    // Random request levels held for random stretches.
    do_reset("rand");
    for (int blk = 0; blk < 300; blk++) begin
      r   = 4'($urandom_range(0, 15));
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) step(r, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
